// File: rtl/pri_voq_requester.sv
`default_nettype none
// ============================================================================
//  Module      : pri_voq_requester
//  Description : Input-port half of a prioritised iSLIP scheduler. Tracks VOQ
//                occupancy per (output, priority), requests each output at its
//                highest pending priority and accepts one returned grant.
//  Revision    : 1.0  initial release
// ============================================================================
module pri_voq_requester #(
    parameter int N = 4,
    parameter int P = 8,
    parameter int C = $clog2(P),
    parameter int D = 16,
    parameter int W = $clog2(D + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_valid,
    input  logic [$clog2(N)-1:0]   enq_out,
    input  logic [C-1:0]           enq_pri,
    output logic                   enq_ready,
    output logic [N-1:0]           req,
    output logic [N-1:0][C-1:0]    pri_req,
    input  logic                   gnt_valid,
    input  logic [N-1:0]           gnt_in,
    input  logic [N-1:0][C-1:0]    gnt_pri,
    input  logic                   update_en,
    output logic [N-1:0]           accept,
    output logic                   any_accept,
    output logic [C-1:0]           accept_pri
);

    localparam int c_idx_w = $clog2(N);

    logic [N-1:0][P-1:0][W-1:0]   r_cnt;
    logic [P-1:0][c_idx_w-1:0]    r_ptr;
    logic [N-1:0]                 r_accept;
    logic                         r_any_accept;
    logic [C-1:0]                 r_accept_pri;

    logic                         w_enq_fire;
    logic [N-1:0]                 w_req;
    logic [N-1:0][C-1:0]          w_pri_req;
    logic [N-1:0]                 w_elig;
    logic [C-1:0]                 w_pmax;
    logic                         w_win_valid;
    logic [c_idx_w-1:0]           w_win;
    logic [c_idx_w:0]             w_idx;
    logic [c_idx_w-1:0]           w_ptr_next;

    assign enq_ready  = (r_cnt[enq_out][enq_pri] != W'(D));
    assign w_enq_fire = enq_valid & enq_ready;

    // Ascending scan so the highest nonzero priority is the one left standing.
    always_comb begin
        w_req     = '0;
        w_pri_req = '0;
        for (int j = 0; j < N; j++) begin
            for (int p = 0; p < P; p++) begin
                if (r_cnt[j][p] != '0) begin
                    w_req[j]     = 1'b1;
                    w_pri_req[j] = C'(p);
                end
            end
        end
    end

    assign req     = w_req;
    assign pri_req = w_pri_req;

    // A grant is usable only if its VOQ still holds a cell, which also keeps counters from underflowing.
    always_comb begin
        w_elig = '0;
        w_pmax = '0;
        for (int j = 0; j < N; j++) begin
            w_elig[j] = gnt_valid & gnt_in[j] & (r_cnt[j][gnt_pri[j]] != '0);
            if (w_elig[j] && (gnt_pri[j] > w_pmax)) begin
                w_pmax = gnt_pri[j];
            end
        end
    end

    always_comb begin
        w_win_valid = 1'b0;
        w_win       = '0;
        w_idx       = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr[w_pmax]} + (c_idx_w + 1)'(k);
            if (w_idx >= (c_idx_w + 1)'(N)) begin
                w_idx = w_idx - (c_idx_w + 1)'(N);
            end
            if (!w_win_valid && w_elig[w_idx[c_idx_w-1:0]] &&
                (gnt_pri[w_idx[c_idx_w-1:0]] == w_pmax)) begin
                w_win_valid = 1'b1;
                w_win       = w_idx[c_idx_w-1:0];
            end
        end
    end

    assign w_ptr_next = (w_win == c_idx_w'(N - 1)) ? '0 : w_win + c_idx_w'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_accept     <= '0;
            r_any_accept <= 1'b0;
            r_accept_pri <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                for (int p = 0; p < P; p++) begin
                    // Simultaneous enqueue and dequeue on one VOQ cancel out.
                    if (w_enq_fire && (enq_out == c_idx_w'(j)) && (enq_pri == C'(p))) begin
                        if (!(w_win_valid && (w_win == c_idx_w'(j)) && (w_pmax == C'(p)))) begin
                            r_cnt[j][p] <= r_cnt[j][p] + W'(1);
                        end
                    end else if (w_win_valid && (w_win == c_idx_w'(j)) && (w_pmax == C'(p))) begin
                        r_cnt[j][p] <= r_cnt[j][p] - W'(1);
                    end
                end
            end
            if (w_win_valid) begin
                r_accept     <= {{(N-1){1'b0}}, 1'b1} << w_win;
                r_any_accept <= 1'b1;
                r_accept_pri <= w_pmax;
                if (update_en) begin
                    r_ptr[w_pmax] <= w_ptr_next;
                end
            end else begin
                r_accept     <= '0;
                r_any_accept <= 1'b0;
                r_accept_pri <= '0;
            end
        end
    end

    assign accept     = r_accept;
    assign any_accept = r_any_accept;
    assign accept_pri = r_accept_pri;

endmodule
`default_nettype wire

// File: tb/tb_pri_voq_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pri_voq_requester
//  Description : Directed vector bench for pri_voq_requester.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pri_voq_requester;

    typedef struct {
        logic             rn;
        logic             ev;
        logic [1:0]       eo;
        logic [2:0]       ep;
        logic             gv;
        logic [3:0]       gi;
        logic [3:0][2:0]  gp;
        logic             ue;
        logic             ck_rdy;
        logic             x_rdy;
        logic [3:0]       x_req;
        logic [3:0][2:0]  x_preq;
        logic [3:0]       x_acc;
        logic             x_any;
        logic [2:0]       x_apri;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             enq_valid;
    logic [1:0]       enq_out;
    logic [2:0]       enq_pri;
    logic             enq_ready;
    logic [3:0]       req;
    logic [3:0][2:0]  pri_req;
    logic             gnt_valid;
    logic [3:0]       gnt_in;
    logic [3:0][2:0]  gnt_pri;
    logic             update_en;
    logic [3:0]       accept;
    logic             any_accept;
    logic [2:0]       accept_pri;

    int n_vec;
    int n_err;

    pri_voq_requester #(.N(4), .P(8), .D(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enq_valid  (enq_valid),
        .enq_out    (enq_out),
        .enq_pri    (enq_pri),
        .enq_ready  (enq_ready),
        .req        (req),
        .pri_req    (pri_req),
        .gnt_valid  (gnt_valid),
        .gnt_in     (gnt_in),
        .gnt_pri    (gnt_pri),
        .update_en  (update_en),
        .accept     (accept),
        .any_accept (any_accept),
        .accept_pri (accept_pri)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rn, logic ev, logic [1:0] eo, logic [2:0] ep,
                                logic gv, logic [3:0] gi, logic [11:0] gp, logic ue,
                                logic ck, logic xr, logic [3:0] xq, logic [11:0] xp,
                                logic [3:0] xa, logic [2:0] xap);
        vec_t v;
        v.rn = rn; v.ev = ev; v.eo = eo; v.ep = ep;
        v.gv = gv; v.gi = gi; v.gp = gp; v.ue = ue;
        v.ck_rdy = ck; v.x_rdy = xr; v.x_req = xq; v.x_preq = xp;
        v.x_acc = xa; v.x_any = |xa; v.x_apri = xap;
        return v;
    endfunction

    task automatic cmp(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    task automatic run(input int id, input vec_t v);
        @(negedge clk);
        reset     = v.rn;
        enq_valid = v.ev;
        enq_out   = v.eo;
        enq_pri   = v.ep;
        gnt_valid = v.gv;
        gnt_in    = v.gi;
        gnt_pri   = v.gp;
        update_en = v.ue;
        #1;
        if (v.ck_rdy) cmp(id, "enq_ready", 32'(enq_ready), 32'(v.x_rdy));
        @(posedge clk);
        #1;
        n_vec++;
        cmp(id, "req",        32'(req),        32'(v.x_req));
        cmp(id, "pri_req",    32'(pri_req),    32'(v.x_preq));
        cmp(id, "accept",     32'(accept),     32'(v.x_acc));
        cmp(id, "any_accept", 32'(any_accept), 32'(v.x_any));
        cmp(id, "accept_pri", 32'(accept_pri), 32'(v.x_apri));
    endtask

    vec_t tbl[$];

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b0; enq_valid = 1'b0; enq_out = '0; enq_pri = '0;
        gnt_valid = 1'b0; gnt_in = '0; gnt_pri = '0; update_en = 1'b0;

        // reset, enqueue, priority selection, stale grants
        tbl.push_back(mk(0,0,0,0, 0,4'b0000,12'h000,0, 0,0, 4'b0000, 12'h000, 4'b0000, 0));
        tbl.push_back(mk(0,0,0,0, 0,4'b0000,12'h000,0, 1,1, 4'b0000, 12'h000, 4'b0000, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1,1,2,5, 0,4'b0000,12'h000,0, 1,1, 4'b0100, {3'd0,3'd5,3'd0,3'd0}, 4'b0000, 0));
        tbl.push_back(mk(1,1,1,3, 0,4'b0000,12'h000,0, 1,1, 4'b0110, {3'd0,3'd5,3'd3,3'd0}, 4'b0000, 0));
        tbl.push_back(mk(1,1,3,6, 0,4'b0000,12'h000,0, 1,1, 4'b1110, {3'd6,3'd5,3'd3,3'd0}, 4'b0000, 0));
        tbl.push_back(mk(1,0,3,6, 1,4'b1010,{3'd6,3'd0,3'd3,3'd0},1, 1,1, 4'b0110, {3'd0,3'd5,3'd3,3'd0}, 4'b1000, 6));
        tbl.push_back(mk(1,0,0,0, 0,4'b0000,12'h000,0, 1,1, 4'b0110, {3'd0,3'd5,3'd3,3'd0}, 4'b0000, 0));
        tbl.push_back(mk(1,0,0,0, 1,4'b0010,{3'd0,3'd0,3'd2,3'd0},0, 1,1, 4'b0110, {3'd0,3'd5,3'd3,3'd0}, 4'b0000, 0));
        tbl.push_back(mk(1,0,0,0, 1,4'b0110,{3'd0,3'd5,3'd3,3'd0},0, 1,1, 4'b0110, {3'd0,3'd5,3'd3,3'd0}, 4'b0100, 5));
        tbl.push_back(mk(1,0,0,0, 0,4'b0000,12'h000,0, 1,1, 4'b0110, {3'd0,3'd5,3'd3,3'd0}, 4'b0000, 0));
        foreach (tbl[i]) run(i, tbl[i]);
        cmp(100, "cnt[2][5]", 32'(dut.r_cnt[2][5]), 32'd2);
        cmp(101, "cnt[3][6]", 32'(dut.r_cnt[3][6]), 32'd0);
        cmp(102, "cnt[1][3]", 32'(dut.r_cnt[1][3]), 32'd1);

        // fill (0,0) to capacity, overflow attempt, then dequeue against a full counter
        run(200, mk(0,0,0,0, 0,4'b0000,12'h000,0, 0,0, 4'b0000, 12'h000, 4'b0000, 0));
        for (int i = 0; i < 16; i++)
            run(201 + i, mk(1,1,0,0, 0,4'b0000,12'h000,0, 1,1, 4'b0001, 12'h000, 4'b0000, 0));
        run(217, mk(1,1,0,0, 0,4'b0000,12'h000,0, 1,0, 4'b0001, 12'h000, 4'b0000, 0));
        cmp(218, "cnt[0][0] full", 32'(dut.r_cnt[0][0]), 32'd16);
        run(219, mk(1,1,0,0, 1,4'b0001,12'h000,0, 1,0, 4'b0001, 12'h000, 4'b0001, 0));
        cmp(220, "cnt[0][0] deq", 32'(dut.r_cnt[0][0]), 32'd15);

        // round-robin at pri4 with update_en=1
        run(300, mk(0,0,0,0, 0,4'b0000,12'h000,0, 0,0, 4'b0000, 12'h000, 4'b0000, 0));
        run(301, mk(1,1,0,4, 0,4'b0000,12'h000,0, 1,1, 4'b0001, {3'd0,3'd0,3'd0,3'd4}, 4'b0000, 0));
        run(302, mk(1,1,0,4, 0,4'b0000,12'h000,0, 1,1, 4'b0001, {3'd0,3'd0,3'd0,3'd4}, 4'b0000, 0));
        run(303, mk(1,1,2,4, 0,4'b0000,12'h000,0, 1,1, 4'b0101, {3'd0,3'd4,3'd0,3'd4}, 4'b0000, 0));
        run(304, mk(1,1,2,4, 0,4'b0000,12'h000,0, 1,1, 4'b0101, {3'd0,3'd4,3'd0,3'd4}, 4'b0000, 0));
        run(305, mk(1,0,0,0, 1,4'b0101,{3'd0,3'd4,3'd0,3'd4},1, 1,1, 4'b0101, {3'd0,3'd4,3'd0,3'd4}, 4'b0001, 4));
        run(306, mk(1,0,0,0, 1,4'b0101,{3'd0,3'd4,3'd0,3'd4},1, 1,1, 4'b0101, {3'd0,3'd4,3'd0,3'd4}, 4'b0100, 4));
        cmp(307, "acc_ptr[4] ue=1", 32'(dut.r_ptr[4]), 32'd3);

        // same sequence with update_en=0
        run(310, mk(0,0,0,0, 0,4'b0000,12'h000,0, 0,0, 4'b0000, 12'h000, 4'b0000, 0));
        run(311, mk(1,1,0,4, 0,4'b0000,12'h000,0, 1,1, 4'b0001, {3'd0,3'd0,3'd0,3'd4}, 4'b0000, 0));
        run(312, mk(1,1,0,4, 0,4'b0000,12'h000,0, 1,1, 4'b0001, {3'd0,3'd0,3'd0,3'd4}, 4'b0000, 0));
        run(313, mk(1,1,2,4, 0,4'b0000,12'h000,0, 1,1, 4'b0101, {3'd0,3'd4,3'd0,3'd4}, 4'b0000, 0));
        run(314, mk(1,1,2,4, 0,4'b0000,12'h000,0, 1,1, 4'b0101, {3'd0,3'd4,3'd0,3'd4}, 4'b0000, 0));
        run(315, mk(1,0,0,0, 1,4'b0101,{3'd0,3'd4,3'd0,3'd4},0, 1,1, 4'b0101, {3'd0,3'd4,3'd0,3'd4}, 4'b0001, 4));
        run(316, mk(1,0,0,0, 1,4'b0101,{3'd0,3'd4,3'd0,3'd4},0, 1,1, 4'b0100, {3'd0,3'd4,3'd0,3'd0}, 4'b0001, 4));
        cmp(317, "acc_ptr[4] ue=0", 32'(dut.r_ptr[4]), 32'd0);

        // pointer wrap: out0 wins first (ptr 1), then out3 wins (ptr wraps to 0)
        run(320, mk(1,1,3,1, 0,4'b0000,12'h000,0, 1,1, 4'b1100, {3'd1,3'd4,3'd0,3'd0}, 4'b0000, 0));
        run(321, mk(1,1,0,1, 0,4'b0000,12'h000,0, 1,1, 4'b1101, {3'd1,3'd4,3'd0,3'd1}, 4'b0000, 0));
        run(322, mk(1,0,0,0, 1,4'b1001,{3'd1,3'd0,3'd0,3'd1},1, 1,1, 4'b1100, {3'd1,3'd4,3'd0,3'd0}, 4'b0001, 1));
        cmp(323, "acc_ptr[1] step", 32'(dut.r_ptr[1]), 32'd1);
        run(324, mk(1,0,0,0, 1,4'b1001,{3'd1,3'd0,3'd0,3'd1},1, 1,1, 4'b0100, {3'd0,3'd4,3'd0,3'd0}, 4'b1000, 1));
        cmp(325, "acc_ptr[1] wrap", 32'(dut.r_ptr[1]), 32'd0);

        // enqueue and dequeue on (0,7) together, then reset on the accept edge
        run(400, mk(0,0,0,0, 0,4'b0000,12'h000,0, 0,0, 4'b0000, 12'h000, 4'b0000, 0));
        run(401, mk(1,1,0,7, 0,4'b0000,12'h000,0, 1,1, 4'b0001, {3'd0,3'd0,3'd0,3'd7}, 4'b0000, 0));
        run(402, mk(1,1,0,7, 1,4'b0001,{3'd0,3'd0,3'd0,3'd7},1, 1,1, 4'b0001, {3'd0,3'd0,3'd0,3'd7}, 4'b0001, 7));
        cmp(403, "cnt[0][7] net", 32'(dut.r_cnt[0][7]), 32'd1);
        run(404, mk(0,0,0,0, 1,4'b0001,{3'd0,3'd0,3'd0,3'd7},1, 1,1, 4'b0000, 12'h000, 4'b0000, 0));
        cmp(405, "cnt[0][7] reset", 32'(dut.r_cnt[0][7]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
